// File: rtl/trdb_pkg.sv
// Shared types for the trace packet scheduler: packet formats, FSM states, buffered entry.
// Pure declarations; no latency or flow control of its own.
package trdb_pkg;

  localparam int RESYNC_CNT_W = 16;

  typedef enum logic [1:0] {FMT_0, FMT_1, FMT_2, FMT_3} trdb_format_e;
  typedef enum logic [1:0] {SF_0, SF_1, SF_2, SF_3} trdb_subformat_e;
  typedef enum logic [1:0] {ST_OFF, ST_START, ST_TRACE, ST_DRAIN} trdb_sched_state_e;

  typedef struct packed {
    trdb_format_e    fmt;
    trdb_subformat_e sub;
  } trdb_pkt_t;

endpackage

// File: rtl/trdb_pkt_fifo.sv
// Packet request FIFO, power-of-two depth, no bypass: a write is visible one cycle later.
// Push while full is accepted only together with a pop; head is held until popped.
module trdb_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             wr_en, rd_en;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PTR_W+1)'(DEPTH));
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  // Empty head reads as zero so idle enum outputs stay at their first value.
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Trace packet scheduler: OFF/START/TRACE/DRAIN FSM, resync counter, buffered packet requests.
// Head valid one cycle after push; full drops unless popped; TRDB_RESYNC_CYCLES_EN counts cycles, else pushes.
module trdb_packet_scheduler
  import trdb_pkg::*;
#(
  parameter logic [RESYNC_CNT_W-1:0] RESYNC_MAX = 16'd64,
  parameter int                      FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              qualified_i,
  input  logic              valid_i,
  input  trdb_format_e      packet_format_i,
  input  trdb_subformat_e   packet_subformat_i,
  input  logic              pkt_ready_i,
  output logic              pkt_valid_o,
  output trdb_format_e      pkt_format_o,
  output trdb_subformat_e   pkt_subformat_o,
  output logic              first_qualified_o,
  output logic              max_resync_o,
  output logic              enc_enabled_o,
  output logic              enc_disabled_o,
  output logic              packets_lost_o,
  output trdb_sched_state_e state_o
);

  trdb_sched_state_e       state_q, state_d;
  logic [RESYNC_CNT_W-1:0] cnt_q;
  trdb_pkt_t               wr_pkt, head_pkt;
  logic fifo_full, fifo_empty, push, pop, push_acc, drop, sync_push, cnt_inc;

  assign wr_pkt.fmt = packet_format_i;
  assign wr_pkt.sub = packet_subformat_i;

  assign push      = valid_i && (state_q != ST_OFF);
  assign pop       = pkt_valid_o && pkt_ready_i;
  assign push_acc  = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;
  assign sync_push = push_acc && (packet_format_i == FMT_3) && (packet_subformat_i == SF_0);

`ifdef TRDB_RESYNC_CYCLES_EN
  assign cnt_inc = (state_q == ST_TRACE);
`else
  assign cnt_inc = (state_q == ST_TRACE) && push_acc;
`endif

  trdb_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(trdb_pkt_t))
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (push_acc),
    .pop      (pop),
    .data_in  (wr_pkt),
    .data_out (head_pkt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pkt_valid_o     = !fifo_empty;
  assign pkt_format_o    = head_pkt.fmt;
  assign pkt_subformat_o = head_pkt.sub;
  assign max_resync_o    = (cnt_q == RESYNC_MAX);
  assign state_o         = state_q;

  // Disable wins over any qualification change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (enable_i) state_d = ST_START;
      ST_START: if (!enable_i) state_d = ST_DRAIN; else if (qualified_i) state_d = ST_TRACE;
      ST_TRACE: if (!enable_i) state_d = ST_DRAIN; else if (!qualified_i) state_d = ST_START;
      ST_DRAIN: if (fifo_empty) state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= ST_OFF;
      cnt_q             <= '0;
      packets_lost_o    <= 1'b0;
      enc_enabled_o     <= 1'b0;
      enc_disabled_o    <= 1'b0;
      first_qualified_o <= 1'b0;
    end else begin
      state_q           <= state_d;
      enc_enabled_o     <= (state_q == ST_OFF) && (state_d == ST_START);
      first_qualified_o <= (state_q == ST_START) && (state_d == ST_TRACE);
      enc_disabled_o    <= (state_q != ST_DRAIN) && (state_d == ST_DRAIN);
      // A sync packet restarts the resync interval, overriding any increment.
      if (sync_push || ((state_q != ST_TRACE) && (state_d == ST_TRACE))) cnt_q <= '0;
      else if (cnt_inc && (cnt_q < RESYNC_MAX)) cnt_q <= cnt_q + RESYNC_CNT_W'(1);
      if (drop) packets_lost_o <= 1'b1;
      else if (sync_push) packets_lost_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Randomized bench for trdb_packet_scheduler: queue-based reference model plus a popping scoreboard.
module tb_trdb_packet_scheduler;
  import trdb_pkg::*;

  localparam int RMAX  = 8;
  localparam int DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              enable_i = 1'b0;
  logic              qualified_i = 1'b0;
  logic              valid_i = 1'b0;
  trdb_format_e      packet_format_i = FMT_0;
  trdb_subformat_e   packet_subformat_i = SF_0;
  logic              pkt_ready_i = 1'b0;
  logic              pkt_valid_o;
  trdb_format_e      pkt_format_o;
  trdb_subformat_e   pkt_subformat_o;
  logic              first_qualified_o, max_resync_o, enc_enabled_o, enc_disabled_o, packets_lost_o;
  trdb_sched_state_e state_o;

  trdb_packet_scheduler #(.RESYNC_MAX(16'(RMAX)), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .qualified_i(qualified_i),
    .valid_i(valid_i), .packet_format_i(packet_format_i), .packet_subformat_i(packet_subformat_i),
    .pkt_ready_i(pkt_ready_i), .pkt_valid_o(pkt_valid_o), .pkt_format_o(pkt_format_o),
    .pkt_subformat_o(pkt_subformat_o), .first_qualified_o(first_qualified_o),
    .max_resync_o(max_resync_o), .enc_enabled_o(enc_enabled_o), .enc_disabled_o(enc_disabled_o),
    .packets_lost_o(packets_lost_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model: values the DUT should present after the most recent rising edge.
  trdb_sched_state_e m_state = ST_OFF;
  int   m_cnt = 0, m_occ = 0;
  logic m_lost = 0, m_een = 0, m_edis = 0, m_fq = 0;
  logic m_known = 0, m_rst_prev = 0;
  trdb_pkt_t exp_q[$];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input logic rst, input logic en, input logic q, input logic v,
                      input trdb_format_e f, input trdb_subformat_e s, input logic rdy);
    logic push, pop, acc, sync;
    trdb_sched_state_e ns;
    trdb_pkt_t p;
    @(negedge clk_i);
    if (m_known) begin
      chk("state", int'(state_o), int'(m_state));
      chk("pkt_valid", int'(pkt_valid_o), int'(m_occ > 0));
      chk("max_resync", int'(max_resync_o), int'(m_cnt == RMAX));
      chk("packets_lost", int'(packets_lost_o), int'(m_lost));
      chk("enc_enabled", int'(enc_enabled_o), int'(m_een));
      chk("enc_disabled", int'(enc_disabled_o), int'(m_edis));
      chk("first_qualified", int'(first_qualified_o), int'(m_fq));
      if (m_rst_prev) begin
        chk("reset_fmt", int'(pkt_format_o), 0);
        chk("reset_subfmt", int'(pkt_subformat_o), 0);
      end
    end
    rst_ni = rst; enable_i = en; qualified_i = q; valid_i = v;
    packet_format_i = f; packet_subformat_i = s; pkt_ready_i = rdy;
    m_rst_prev = !rst;
    if (!rst) begin
      m_state = ST_OFF; m_cnt = 0; m_occ = 0; m_lost = 0;
      m_een = 0; m_edis = 0; m_fq = 0; m_known = 1;
      exp_q.delete();
      return;
    end
    push = v && (m_state != ST_OFF);
    pop  = (m_occ > 0) && rdy;
    acc  = push && (m_occ < DEPTH || pop);
    sync = acc && (f == FMT_3) && (s == SF_0);
    ns = m_state;
    if (m_state == ST_OFF && en) ns = ST_START;
    else if ((m_state == ST_START || m_state == ST_TRACE) && !en) ns = ST_DRAIN;
    else if (m_state == ST_START && q) ns = ST_TRACE;
    else if (m_state == ST_TRACE && !q) ns = ST_START;
    else if (m_state == ST_DRAIN && m_occ == 0) ns = ST_OFF;
    m_een  = (ns == ST_START) && (m_state == ST_OFF);
    m_fq   = (ns == ST_TRACE) && (m_state == ST_START);
    m_edis = (ns == ST_DRAIN) && (m_state != ST_DRAIN);
    if (sync || (ns == ST_TRACE && m_state != ST_TRACE)) m_cnt = 0;
`ifdef TRDB_RESYNC_CYCLES_EN
    else if (m_state == ST_TRACE) m_cnt = (m_cnt + 1 > RMAX) ? RMAX : m_cnt + 1;
`else
    else if (m_state == ST_TRACE && acc) m_cnt = (m_cnt + 1 > RMAX) ? RMAX : m_cnt + 1;
`endif
    if (push && !acc) m_lost = 1;
    else if (sync) m_lost = 0;
    if (acc) begin
      p.fmt = f; p.sub = s;
      exp_q.push_back(p);
    end
    m_occ = m_occ + int'(acc) - int'(pop);
    m_state = ns;
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected entry.
  initial begin
    trdb_pkt_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && pkt_valid_o && pkt_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pop_fmt", int'(pkt_format_o), int'(e.fmt));
          chk("pop_subfmt", int'(pkt_subformat_o), int'(e.sub));
        end
      end
    end
  end

  initial begin
    int rdy_pct;
    logic r;
    repeat (2) step(0, 0, 0, 0, FMT_0, SF_0, 0);
    // Start-up: START then TRACE with enable and qualified held high.
    repeat (3) step(1, 1, 1, 0, FMT_0, SF_0, 0);
    // Overfill with ready low: fifth push dropped, then a sync push clears the flag.
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, FMT_1, trdb_subformat_e'(i % 4), 0);
    step(1, 1, 1, 0, FMT_0, SF_0, 0);
    step(1, 1, 1, 1, FMT_3, SF_0, 1);
    step(1, 1, 1, 0, FMT_0, SF_0, 0);
    // Full FIFO with simultaneous push and pop keeps occupancy and order.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, FMT_2, trdb_subformat_e'(i % 4), 1);
    // Saturate the resync counter, then clear it with a sync push.
    for (int i = 0; i < 12; i++) step(1, 1, 1, 1, FMT_1, SF_2, 1);
    step(1, 1, 1, 1, FMT_3, SF_0, 1);
    repeat (4) step(1, 1, 1, 0, FMT_0, SF_0, 1);
    // Disable with three queued: DRAIN holds until the FIFO empties.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, FMT_2, SF_1, 0);
    repeat (3) step(1, 0, 1, 0, FMT_0, SF_0, 0);
    step(1, 1, 1, 0, FMT_0, SF_0, 0);
    repeat (6) step(1, 0, 0, 0, FMT_0, SF_0, 1);
    // Reset with two entries queued discards them.
    repeat (3) step(1, 1, 1, 0, FMT_0, SF_0, 0);
    repeat (2) step(1, 1, 1, 1, FMT_1, SF_1, 0);
    step(0, 1, 1, 0, FMT_0, SF_0, 0);
    repeat (2) step(1, 1, 1, 0, FMT_0, SF_0, 0);
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 400) % 2 == 1) ? 85 : 30;
      r = ($urandom_range(0, 299) != 0);
      step(r, $urandom_range(0, 99) < 92, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 60, trdb_format_e'($urandom_range(0, 3)),
           trdb_subformat_e'($urandom_range(0, 3)), $urandom_range(0, 99) < rdy_pct);
    end
    repeat (15) step(1, 0, 0, 0, FMT_0, SF_0, 1);
    @(negedge clk_i);
    #3;
    chk("drain_empty", exp_q.size(), 0);
    chk("final_state", int'(state_o), int'(ST_OFF));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
